ptmch_trg_gen: RTL and testbench

//  Trigger-pulse generator: drives the 5-bit TRG_PLS bus consumed by the ptmch pulse counters.

---
 rtl/ptmch_pkg.sv | 20 ++
 rtl/ptmch_phase_tmr.sv | 28 ++
 rtl/ptmch_trg_gen.sv | 190 +++++++++++++++++++
 tb/tb_ptmch_trg_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptmch_pkg.sv
// Shared types and constants for the ptmch trigger-pulse generator.
// Channel indices follow the TRG_PLS bit order used by the ptmch pulse counters.
package ptmch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } trg_st_t;

  localparam int CH_PRGEXCT = 0;
  localparam int CH_RDSTAT  = 1;
  localparam int CH_BLKERS  = 2;
  localparam int CH_PDREAD  = 3;
  localparam int CH_WRSTAT  = 4;

  localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/ptmch_phase_tmr.sv
// Phase-length down-counter: load with (width-1), counts to zero and holds there.
// expired is high in the last cycle of the phase.
module ptmch_phase_tmr #(
  parameter int WID_W = 8
) (
  input  logic             CLK100M,
  input  logic             RESET_N,
  input  logic             load,
  input  logic [WID_W-1:0] load_val,
  output logic             expired
);

  logic [WID_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ptmch_trg_gen.sv
// Burst trigger-pulse generator for the ptmch TRG_PLS bus, with per-channel
// saturating sent-pulse counters for software cross-checking.
module ptmch_trg_gen
  import ptmch_pkg::*;
#(
  parameter int NUM_CH = CH_WRSTAT + 1,
  parameter int CNT_W  = 16,
  parameter int WID_W  = 8,
  parameter int MIN_W  = 3
) (
  input  logic                  CLK100M,
  input  logic                  RESET_N,
  input  logic                  CMD_VLD,
  output logic                  CMD_RDY,
  input  logic [2:0]            CMD_CH,
  input  logic [CNT_W-1:0]      CMD_NUM,
  input  logic [WID_W-1:0]      CMD_HIGH,
  input  logic [WID_W-1:0]      CMD_LOW,
  input  logic                  ABORT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  DONE_ERR,
  output logic [NUM_CH-1:0]     TRG_PLS,
  output logic [32*NUM_CH-1:0]  SENT_CNT
);

  trg_st_t          st;
  logic [2:0]       ch_q;
  logic [CNT_W-1:0] rem_q;
  logic [WID_W-1:0] high_ld_q;
  logic [WID_W-1:0] low_ld_q;
  logic             abort_q;
  logic [NUM_CH-1:0] trg_q;
  logic             done_q;
  logic             err_q;

  logic             tmr_load;
  logic [WID_W-1:0] tmr_val;
  logic             tmr_exp;

  logic             cmd_bad;
  logic             hi_entry;
  logic [2:0]       ent_ch;
  logic [NUM_CH-1:0] inc;

  // Timer reload value for a requested width: clamp to MIN_W, then minus one.
  function automatic logic [WID_W-1:0] ld_val(input logic [WID_W-1:0] w);
    if (w < WID_W'(MIN_W)) begin
      return WID_W'(MIN_W - 1);
    end
    return w - 1'b1;
  endfunction

  assign cmd_bad = (int'(CMD_CH) >= NUM_CH) || (CMD_NUM == '0);

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    hi_entry = 1'b0;
    ent_ch   = ch_q;
    unique case (st)
      ST_IDLE: begin
        ent_ch = CMD_CH;
        if (CMD_VLD && !cmd_bad) begin
          tmr_load = 1'b1;
          tmr_val  = ld_val(CMD_HIGH);
          hi_entry = 1'b1;
        end
      end
      ST_HIGH: begin
        if (ABORT || tmr_exp) begin
          tmr_load = 1'b1;
          tmr_val  = low_ld_q;
        end
      end
      ST_LOW: begin
        if (tmr_exp && !ABORT && rem_q != '0) begin
          tmr_load = 1'b1;
          tmr_val  = high_ld_q;
          hi_entry = 1'b1;
        end
      end
      default: ;
    endcase
  end

  ptmch_phase_tmr #(.WID_W(WID_W)) u_phase_tmr (
    .CLK100M  (CLK100M),
    .RESET_N  (RESET_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      st        <= ST_IDLE;
      ch_q      <= '0;
      rem_q     <= '0;
      high_ld_q <= '0;
      low_ld_q  <= '0;
      abort_q   <= 1'b0;
      trg_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          if (CMD_VLD) begin
            ch_q      <= CMD_CH;
            high_ld_q <= ld_val(CMD_HIGH);
            low_ld_q  <= ld_val(CMD_LOW);
            abort_q   <= 1'b0;
            if (cmd_bad) begin
              st     <= ST_DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              st    <= ST_HIGH;
              trg_q <= NUM_CH'(1) << CMD_CH;
              rem_q <= CMD_NUM - 1'b1;
            end
          end
        end
        ST_HIGH: begin
          if (ABORT || tmr_exp) begin
            st    <= ST_LOW;
            trg_q <= '0;
          end
          if (ABORT) begin
            abort_q <= 1'b1;
            rem_q   <= '0;
          end
        end
        ST_LOW: begin
          if (ABORT) begin
            abort_q <= 1'b1;
            rem_q   <= '0;
          end
          if (tmr_exp) begin
            if (!ABORT && rem_q != '0) begin
              st    <= ST_HIGH;
              trg_q <= NUM_CH'(1) << ch_q;
              rem_q <= rem_q - 1'b1;
            end else begin
              st     <= ST_DONE;
              done_q <= 1'b1;
              err_q  <= abort_q || ABORT;
            end
          end
        end
        default: begin
          st <= ST_IDLE;
        end
      endcase
    end
  end

  // One increment strobe per channel; the first pulse uses the live CMD_CH since ch_q loads on the same edge.
  always_comb begin
    inc = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      inc[c] = hi_entry && (int'(ent_ch) == c);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_sent
    logic [31:0] cnt;

    always_ff @(posedge CLK100M or negedge RESET_N) begin
      if (!RESET_N) begin
        cnt <= '0;
      end else if (inc[c] && cnt != CNT_SAT) begin
        cnt <= cnt + 32'd1;
      end
    end

    assign SENT_CNT[32*c +: 32] = cnt;
  end

  assign TRG_PLS  = trg_q;
  assign DONE     = done_q;
  assign DONE_ERR = err_q;
  assign BUSY     = (st != ST_IDLE);
  assign CMD_RDY  = (st == ST_IDLE);

endmodule

// File: tb/tb_ptmch_trg_gen.sv
// Directed bench for ptmch_trg_gen: burst timing, clamping, rejects, aborts,
// counter saturation and asynchronous reset.
module tb_ptmch_trg_gen;
  import ptmch_pkg::*;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 16;
  localparam int WID_W  = 8;

  logic                 CLK100M = 1'b0;
  logic                 RESET_N = 1'b0;
  logic                 CMD_VLD = 1'b0;
  logic                 CMD_RDY;
  logic [2:0]           CMD_CH = '0;
  logic [CNT_W-1:0]     CMD_NUM = '0;
  logic [WID_W-1:0]     CMD_HIGH = '0;
  logic [WID_W-1:0]     CMD_LOW = '0;
  logic                 ABORT = 1'b0;
  logic                 BUSY;
  logic                 DONE;
  logic                 DONE_ERR;
  logic [NUM_CH-1:0]    TRG_PLS;
  logic [32*NUM_CH-1:0] SENT_CNT;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [31:0] exp_sent [NUM_CH];

  ptmch_trg_gen dut (
    .CLK100M  (CLK100M),
    .RESET_N  (RESET_N),
    .CMD_VLD  (CMD_VLD),
    .CMD_RDY  (CMD_RDY),
    .CMD_CH   (CMD_CH),
    .CMD_NUM  (CMD_NUM),
    .CMD_HIGH (CMD_HIGH),
    .CMD_LOW  (CMD_LOW),
    .ABORT    (ABORT),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .DONE_ERR (DONE_ERR),
    .TRG_PLS  (TRG_PLS),
    .SENT_CNT (SENT_CNT)
  );

  always #5 CLK100M = ~CLK100M;

  function automatic logic [32*NUM_CH-1:0] exp_sent_vec();
    logic [32*NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[32*c +: 32] = exp_sent[c];
    return v;
  endfunction

  // Expected TRG_PLS in cycle k after accept (k=1 is the first cycle after the accept edge).
  function automatic logic [NUM_CH-1:0] exp_trg(input int k, input int ch, input int eh,
                                                input int el, input int num);
    logic [NUM_CH-1:0] one;
    int p;
    one = 1;
    if (k < 1 || k > num * (eh + el)) return '0;
    p = (k - 1) % (eh + el);
    return (p < eh) ? (one << ch) : '0;
  endfunction

  // Drive one command for a single accept edge, then scramble the fields.
  task automatic send_cmd(input logic [2:0] ch, input int num, input int hi, input int lo);
    @(negedge CLK100M);
    CMD_CH   = ch;
    CMD_NUM  = CNT_W'(num);
    CMD_HIGH = WID_W'(hi);
    CMD_LOW  = WID_W'(lo);
    CMD_VLD  = 1'b1;
    @(posedge CLK100M);
    #1;
    CMD_VLD  = 1'b0;
    CMD_CH   = 3'd6;
    CMD_NUM  = '1;
    CMD_HIGH = 8'd1;
    CMD_LOW  = 8'd1;
  endtask

  task automatic test_reset();
    #12;
    chk_cnt++; if (TRG_PLS !== '0) $display("FAIL reset_trg got %b want 0", TRG_PLS); else pass_cnt++;
    chk_cnt++; if (CMD_RDY !== 1'b1) $display("FAIL reset_rdy got %b want 1", CMD_RDY); else pass_cnt++;
    chk_cnt++; if (BUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", BUSY); else pass_cnt++;
    chk_cnt++; if ({DONE, DONE_ERR} !== 2'b00) $display("FAIL reset_done got %b want 00", {DONE, DONE_ERR}); else pass_cnt++;
    chk_cnt++; if (SENT_CNT !== '0) $display("FAIL reset_sent got %h want 0", SENT_CNT); else pass_cnt++;
    @(negedge CLK100M);
    RESET_N = 1'b1;
  endtask

  task automatic test_burst();
    send_cmd(3'd0, 3, 4, 5);
    for (int k = 1; k <= 29; k++) begin
      @(negedge CLK100M);
      chk_cnt++; if (TRG_PLS !== exp_trg(k, 0, 4, 5, 3)) $display("FAIL burst_trg k=%0d got %b want %b", k, TRG_PLS, exp_trg(k, 0, 4, 5, 3)); else pass_cnt++;
      chk_cnt++; if (DONE !== (k == 28)) $display("FAIL burst_done k=%0d got %b want %b", k, DONE, k == 28); else pass_cnt++;
      chk_cnt++; if (BUSY !== (k <= 28)) $display("FAIL burst_busy k=%0d got %b want %b", k, BUSY, k <= 28); else pass_cnt++;
      if (k == 28) begin
        chk_cnt++; if (DONE_ERR !== 1'b0) $display("FAIL burst_err got %b want 0", DONE_ERR); else pass_cnt++;
      end
    end
    exp_sent[0] = 32'd3;
    chk_cnt++; if (SENT_CNT !== exp_sent_vec()) $display("FAIL burst_sent got %h want %h", SENT_CNT, exp_sent_vec()); else pass_cnt++;
  endtask

  task automatic test_clamp();
    send_cmd(3'd2, 1, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK100M);
      chk_cnt++; if (TRG_PLS !== exp_trg(k, 2, 3, 3, 1)) $display("FAIL clamp_trg k=%0d got %b want %b", k, TRG_PLS, exp_trg(k, 2, 3, 3, 1)); else pass_cnt++;
      chk_cnt++; if (DONE !== (k == 7)) $display("FAIL clamp_done k=%0d got %b want %b", k, DONE, k == 7); else pass_cnt++;
      if (k == 7) begin
        chk_cnt++; if (DONE_ERR !== 1'b0) $display("FAIL clamp_err got %b want 0", DONE_ERR); else pass_cnt++;
      end
    end
    exp_sent[2] = 32'd1;
    chk_cnt++; if (SENT_CNT !== exp_sent_vec()) $display("FAIL clamp_sent got %h want %h", SENT_CNT, exp_sent_vec()); else pass_cnt++;
  endtask

  task automatic test_reject();
    send_cmd(3'd5, 4, 4, 4);
    @(negedge CLK100M);
    chk_cnt++; if ({DONE, DONE_ERR, BUSY, CMD_RDY} !== 4'b1110) $display("FAIL rej_ch_done got %b want 1110", {DONE, DONE_ERR, BUSY, CMD_RDY}); else pass_cnt++;
    chk_cnt++; if (TRG_PLS !== '0) $display("FAIL rej_ch_trg got %b want 0", TRG_PLS); else pass_cnt++;
    @(negedge CLK100M);
    chk_cnt++; if ({DONE, BUSY, CMD_RDY} !== 3'b001) $display("FAIL rej_ch_idle got %b want 001", {DONE, BUSY, CMD_RDY}); else pass_cnt++;
    send_cmd(3'd1, 0, 4, 4);
    @(negedge CLK100M);
    chk_cnt++; if ({DONE, DONE_ERR, TRG_PLS} !== {2'b11, 5'b0}) $display("FAIL rej_num_done got %b want 1100000", {DONE, DONE_ERR, TRG_PLS}); else pass_cnt++;
    @(negedge CLK100M);
    chk_cnt++; if (SENT_CNT !== exp_sent_vec()) $display("FAIL rej_sent got %h want %h", SENT_CNT, exp_sent_vec()); else pass_cnt++;
  endtask

  task automatic test_abort_high();
    logic [NUM_CH-1:0] want;
    send_cmd(3'd4, 10, 4, 5);
    for (int k = 1; k <= 18; k++) begin
      @(negedge CLK100M);
      want = (k <= 11) ? exp_trg(k, 4, 4, 5, 10) : '0;
      chk_cnt++; if (TRG_PLS !== want) $display("FAIL abh_trg k=%0d got %b want %b", k, TRG_PLS, want); else pass_cnt++;
      chk_cnt++; if (DONE !== (k == 17)) $display("FAIL abh_done k=%0d got %b want %b", k, DONE, k == 17); else pass_cnt++;
      if (k == 17) begin
        chk_cnt++; if (DONE_ERR !== 1'b1) $display("FAIL abh_err got %b want 1", DONE_ERR); else pass_cnt++;
      end
      if (k == 11) begin
        ABORT = 1'b1;
        @(posedge CLK100M);
        #1;
        ABORT = 1'b0;
      end
    end
    exp_sent[4] = 32'd2;
    chk_cnt++; if (SENT_CNT !== exp_sent_vec()) $display("FAIL abh_sent got %h want %h", SENT_CNT, exp_sent_vec()); else pass_cnt++;
  endtask

  task automatic test_abort_low();
    send_cmd(3'd3, 3, 3, 4);
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK100M);
      chk_cnt++; if (TRG_PLS !== exp_trg(k, 3, 3, 4, 1)) $display("FAIL abl_trg k=%0d got %b want %b", k, TRG_PLS, exp_trg(k, 3, 3, 4, 1)); else pass_cnt++;
      chk_cnt++; if (DONE !== (k == 8)) $display("FAIL abl_done k=%0d got %b want %b", k, DONE, k == 8); else pass_cnt++;
      if (k == 8) begin
        chk_cnt++; if (DONE_ERR !== 1'b1) $display("FAIL abl_err got %b want 1", DONE_ERR); else pass_cnt++;
      end
      if (k == 5) begin
        ABORT = 1'b1;
        @(posedge CLK100M);
        #1;
        ABORT = 1'b0;
      end
    end
    exp_sent[3] = 32'd1;
    chk_cnt++; if (SENT_CNT !== exp_sent_vec()) $display("FAIL abl_sent got %h want %h", SENT_CNT, exp_sent_vec()); else pass_cnt++;
  endtask

  task automatic test_abort_idle();
    ABORT = 1'b1;
    send_cmd(3'd1, 1, 3, 3);
    ABORT = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK100M);
      chk_cnt++; if (TRG_PLS !== exp_trg(k, 1, 3, 3, 1)) $display("FAIL abi_trg k=%0d got %b want %b", k, TRG_PLS, exp_trg(k, 1, 3, 3, 1)); else pass_cnt++;
      if (k == 7) begin
        chk_cnt++; if ({DONE, DONE_ERR} !== 2'b10) $display("FAIL abi_done got %b want 10", {DONE, DONE_ERR}); else pass_cnt++;
      end
    end
    exp_sent[1] = 32'd1;
    chk_cnt++; if (SENT_CNT !== exp_sent_vec()) $display("FAIL abi_sent got %h want %h", SENT_CNT, exp_sent_vec()); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(negedge CLK100M);
    CMD_CH = 3'd3; CMD_NUM = 16'd1; CMD_HIGH = 8'd3; CMD_LOW = 8'd3; CMD_VLD = 1'b1;
    @(posedge CLK100M);
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK100M);
      if (k == 7) begin
        chk_cnt++; if ({DONE, CMD_RDY} !== 2'b10) $display("FAIL b2b_done got %b want 10", {DONE, CMD_RDY}); else pass_cnt++;
      end
      if (k == 8) begin
        chk_cnt++; if ({CMD_RDY, TRG_PLS} !== {1'b1, 5'b0}) $display("FAIL b2b_idle got %b want 100000", {CMD_RDY, TRG_PLS}); else pass_cnt++;
      end
      if (k == 9) begin
        chk_cnt++; if (TRG_PLS !== 5'b01000) $display("FAIL b2b_trg got %b want 01000", TRG_PLS); else pass_cnt++;
        CMD_VLD = 1'b0;
      end
      if (k == 15) begin
        chk_cnt++; if ({DONE, DONE_ERR} !== 2'b10) $display("FAIL b2b_done2 got %b want 10", {DONE, DONE_ERR}); else pass_cnt++;
      end
    end
    exp_sent[3] = exp_sent[3] + 32'd2;
    chk_cnt++; if (SENT_CNT !== exp_sent_vec()) $display("FAIL b2b_sent got %h want %h", SENT_CNT, exp_sent_vec()); else pass_cnt++;
  endtask

  task automatic test_saturate();
    @(negedge CLK100M);
    force dut.g_sent[1].cnt = 32'hFFFF_FFFE;
    #1;
    release dut.g_sent[1].cnt;
    exp_sent[1] = 32'hFFFF_FFFE;
    #1;
    chk_cnt++; if (SENT_CNT !== exp_sent_vec()) $display("FAIL sat_preload got %h want %h", SENT_CNT, exp_sent_vec()); else pass_cnt++;
    send_cmd(3'd1, 3, 3, 3);
    for (int k = 1; k <= 19; k++) begin
      @(negedge CLK100M);
      chk_cnt++; if (TRG_PLS !== exp_trg(k, 1, 3, 3, 3)) $display("FAIL sat_trg k=%0d got %b want %b", k, TRG_PLS, exp_trg(k, 1, 3, 3, 3)); else pass_cnt++;
      if (k == 1 || k == 13) begin
        chk_cnt++; if (SENT_CNT[63:32] !== CNT_SAT) $display("FAIL sat_cnt k=%0d got %h want %h", k, SENT_CNT[63:32], CNT_SAT); else pass_cnt++;
      end
      if (k == 19) begin
        chk_cnt++; if ({DONE, DONE_ERR} !== 2'b10) $display("FAIL sat_done got %b want 10", {DONE, DONE_ERR}); else pass_cnt++;
      end
    end
    exp_sent[1] = CNT_SAT;
    chk_cnt++; if (SENT_CNT !== exp_sent_vec()) $display("FAIL sat_sent got %h want %h", SENT_CNT, exp_sent_vec()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    send_cmd(3'd0, 5, 10, 3);
    @(negedge CLK100M);
    @(negedge CLK100M);
    @(negedge CLK100M);
    chk_cnt++; if (TRG_PLS !== 5'b00001) $display("FAIL rst_pre_trg got %b want 00001", TRG_PLS); else pass_cnt++;
    #2;
    RESET_N = 1'b0;
    #1;
    chk_cnt++; if (TRG_PLS !== '0) $display("FAIL rst_async_trg got %b want 0", TRG_PLS); else pass_cnt++;
    for (int c = 0; c < NUM_CH; c++) exp_sent[c] = '0;
    @(negedge CLK100M);
    chk_cnt++; if (DONE !== 1'b0) $display("FAIL rst_done got %b want 0", DONE); else pass_cnt++;
    RESET_N = 1'b1;
    @(negedge CLK100M);
    chk_cnt++; if ({CMD_RDY, BUSY, DONE, TRG_PLS} !== {3'b100, 5'b0}) $display("FAIL rst_idle got %b want 10000000", {CMD_RDY, BUSY, DONE, TRG_PLS}); else pass_cnt++;
    chk_cnt++; if (SENT_CNT !== exp_sent_vec()) $display("FAIL rst_sent got %h want %h", SENT_CNT, exp_sent_vec()); else pass_cnt++;
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) exp_sent[c] = '0;
    test_reset();
    test_burst();
    test_clamp();
    test_reject();
    test_abort_high();
    test_abort_low();
    test_abort_idle();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
